// File: rtl/tlul_pkg.sv
// TL-UL channel types shared by the debug bus bridge.
// A and D opcodes live in separate enums since their encodings overlap.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    Get            = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } tl_d_op_e;

  typedef logic [1:0] tl_size_t;

  localparam int TlSourceW = 8;

  function automatic tl_size_t tl_word_size(input int bus_w);
    return tl_size_t'($clog2(bus_w / 8));
  endfunction

endpackage

// File: rtl/dm_sba_tlul_bridge_if.sv
// SBA master port and TL-UL host port bundles for the debug bridge.
// Signal names carry the bridge-side direction suffix.
interface dm_sba_if #(
  parameter int BusWidth = 32
);
  localparam int BeW = BusWidth / 8;

  logic                master_req_i;
  logic [BusWidth-1:0] master_add_i;
  logic                master_we_i;
  logic [BusWidth-1:0] master_wdata_i;
  logic [BeW-1:0]      master_be_i;
  logic                master_gnt_o;
  logic                master_r_valid_o;
  logic [BusWidth-1:0] master_r_rdata_o;
  logic                master_err_o;

  modport slave (
    input  master_req_i,
    input  master_add_i,
    input  master_we_i,
    input  master_wdata_i,
    input  master_be_i,
    output master_gnt_o,
    output master_r_valid_o,
    output master_r_rdata_o,
    output master_err_o
  );

  modport master (
    output master_req_i,
    output master_add_i,
    output master_we_i,
    output master_wdata_i,
    output master_be_i,
    input  master_gnt_o,
    input  master_r_valid_o,
    input  master_r_rdata_o,
    input  master_err_o
  );
endinterface

interface tlul_if #(
  parameter int BusWidth = 32
);
  localparam int BeW = BusWidth / 8;

  logic                tl_a_valid_o;
  logic                tl_a_ready_i;
  logic [2:0]          tl_a_opcode_o;
  logic [1:0]          tl_a_size_o;
  logic [BusWidth-1:0] tl_a_address_o;
  logic [BeW-1:0]      tl_a_mask_o;
  logic [BusWidth-1:0] tl_a_data_o;
  logic [7:0]          tl_a_source_o;
  logic                tl_d_valid_i;
  logic                tl_d_ready_o;
  logic [2:0]          tl_d_opcode_i;
  logic [7:0]          tl_d_source_i;
  logic [BusWidth-1:0] tl_d_data_i;
  logic                tl_d_error_i;

  modport host (
    output tl_a_valid_o,
    input  tl_a_ready_i,
    output tl_a_opcode_o,
    output tl_a_size_o,
    output tl_a_address_o,
    output tl_a_mask_o,
    output tl_a_data_o,
    output tl_a_source_o,
    input  tl_d_valid_i,
    output tl_d_ready_o,
    input  tl_d_opcode_i,
    input  tl_d_source_i,
    input  tl_d_data_i,
    input  tl_d_error_i
  );

  modport device (
    input  tl_a_valid_o,
    output tl_a_ready_i,
    input  tl_a_opcode_o,
    input  tl_a_size_o,
    input  tl_a_address_o,
    input  tl_a_mask_o,
    input  tl_a_data_o,
    input  tl_a_source_o,
    output tl_d_valid_i,
    input  tl_d_ready_o,
    output tl_d_opcode_i,
    output tl_d_source_i,
    output tl_d_data_i,
    output tl_d_error_i
  );
endinterface

// File: rtl/dm_sba_tlul_bridge_timeout.sv
// D-channel wait counter: cleared outside WaitD, saturates at Cycles-1.
// Only instantiated when DM_SBA_TLUL_TIMEOUT_EN is defined.
module dm_sba_timeout #(
  parameter int Cycles = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int CntW = $clog2(Cycles) + 1;
  localparam logic [CntW-1:0] Last = CntW'(Cycles - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != Last)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == Last);

endmodule

// File: rtl/dm_sba_tlul_bridge.sv
// SBA master to TL-UL host bridge, one outstanding transaction.
// Optional D-channel timeout under DM_SBA_TLUL_TIMEOUT_EN.
module dm_sba_tlul_bridge
  import tlul_pkg::*;
#(
  parameter int BusWidth      = 32,
  parameter int SourceId      = 0,
  parameter int TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dmactive_i,
  dm_sba_if.slave     sba,
  tlul_if.host        tl
);
  localparam int BeW = BusWidth / 8;
  localparam logic [BusWidth-1:0] LowMask = BusWidth'(BeW - 1);
  localparam logic [TlSourceW-1:0] SrcId = TlSourceW'(SourceId);

  typedef enum logic [1:0] {
    StIdle,
    StWaitD,
    StResp
  } state_e;

  state_e r_state;
  state_e w_next;

  logic                r_exp_put;
  logic                r_err;
  logic [BusWidth-1:0] r_rdata;

  logic           w_a_valid;
  logic           w_gnt;
  logic           w_expire;
  logic           w_d_err;
  logic [2:0]     w_exp_d;
  tl_a_op_e       w_a_op;
  logic [BeW-1:0] w_mask;

  // A payload is a pure function of the current SBA request
  always_comb begin
    w_a_op = Get;
    w_mask = '1;
    unique case (1'b1)
      !sba.master_we_i: begin
        w_a_op = Get;
        w_mask = '1;
      end
      sba.master_we_i && (&sba.master_be_i): begin
        w_a_op = PutFullData;
        w_mask = sba.master_be_i;
      end
      sba.master_we_i && !(&sba.master_be_i): begin
        w_a_op = PutPartialData;
        w_mask = sba.master_be_i;
      end
      default: begin
        w_a_op = Get;
        w_mask = '1;
      end
    endcase
  end

  assign w_a_valid = (r_state == StIdle)
                   && dmactive_i
                   && sba.master_req_i;
  assign w_gnt = w_a_valid && tl.tl_a_ready_i;

  assign tl.tl_a_valid_o   = w_a_valid;
  assign tl.tl_a_opcode_o  = w_a_op;
  assign tl.tl_a_size_o    = tl_word_size(BusWidth);
  assign tl.tl_a_address_o = sba.master_add_i & ~LowMask;
  assign tl.tl_a_mask_o    = w_mask;
  assign tl.tl_a_data_o    = sba.master_wdata_i;
  assign tl.tl_a_source_o  = SrcId;
  assign tl.tl_d_ready_o   = 1'b1;

  assign w_exp_d = r_exp_put ? 3'(AccessAck)
                             : 3'(AccessAckData);
  assign w_d_err = tl.tl_d_error_i
                || (tl.tl_d_opcode_i != w_exp_d)
                || (tl.tl_d_source_i != SrcId);

`ifdef DM_SBA_TLUL_TIMEOUT_EN
  logic w_to_en;
  logic w_to_clr;

  assign w_to_en  = (r_state == StWaitD);
  assign w_to_clr = !dmactive_i || (r_state != StWaitD);

  dm_sba_timeout #(
    .Cycles (TimeoutCycles)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_clr    (w_to_clr),
    .i_en     (w_to_en),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_gnt) w_next = StWaitD;
      end
      StWaitD: begin
        if (tl.tl_d_valid_i || w_expire) w_next = StResp;
      end
      StResp: begin
        w_next = StIdle;
      end
      default: begin
        w_next = StIdle;
      end
    endcase
    if (!dmactive_i) w_next = StIdle;
  end

  // A real D beat wins over a timeout landing in the same cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_exp_put <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else if (!dmactive_i) begin
      r_exp_put <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else if (w_gnt) begin
      r_exp_put <= sba.master_we_i;
    end else if (r_state == StWaitD) begin
      if (tl.tl_d_valid_i) begin
        r_rdata <= tl.tl_d_data_i;
        r_err   <= w_d_err;
      end else if (w_expire) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  assign sba.master_gnt_o     = w_gnt;
  assign sba.master_r_valid_o = (r_state == StResp);
  assign sba.master_r_rdata_o = r_rdata;
  assign sba.master_err_o     = r_err;

endmodule

// File: tb/tb_dm_sba_tlul_bridge.sv
// Directed and randomized bench for dm_sba_tlul_bridge.
// Expected TL-UL fields and errors come from a word-level model.
module tb_dm_sba_tlul_bridge;
  localparam int BW = 32;
`ifdef DM_SBA_TLUL_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif
  localparam logic [7:0] SRC = 8'd0;

  logic clk = 1'b0;
  logic rst_n;
  logic dmactive;
  int checks = 0;
  int failures = 0;

  dm_sba_if #(.BusWidth(BW)) sba_bus ();
  tlul_if   #(.BusWidth(BW)) tl_bus ();

  dm_sba_tlul_bridge #(
    .BusWidth      (BW),
    .SourceId      (0),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .dmactive_i (dmactive),
    .sba        (sba_bus),
    .tl         (tl_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input bit we,
                         input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input logic [3:0] be,
                         input int a_dly,
                         input int d_dly,
                         input logic [2:0] d_op,
                         input logic [7:0] d_src,
                         input bit d_err,
                         input logic [31:0] d_data,
                         input bit stray_at_grant);
    logic [2:0] e_op;
    logic [3:0] e_mask;
    logic [31:0] e_addr;
    bit e_err;
    e_op   = !we ? 3'd4 : ((be == 4'hF) ? 3'd0 : 3'd1);
    e_mask = we ? be : 4'hF;
    e_addr = (addr / 32'd4) * 32'd4;
    e_err  = d_err
          || (d_op != (we ? 3'd0 : 3'd1))
          || (d_src != SRC);
    sba_bus.master_req_i   = 1'b1;
    sba_bus.master_we_i    = we;
    sba_bus.master_add_i   = addr;
    sba_bus.master_wdata_i = wdata;
    sba_bus.master_be_i    = be;
    tl_bus.tl_a_ready_i    = 1'b0;
    for (int i = 0; i < a_dly; i++) begin
      #1;
      chk("a_valid_stall", tl_bus.tl_a_valid_o, 1);
      chk("gnt_stall", sba_bus.master_gnt_o, 0);
      @(negedge clk);
    end
    tl_bus.tl_a_ready_i = 1'b1;
    if (stray_at_grant) begin
      tl_bus.tl_d_valid_i  = 1'b1;
      tl_bus.tl_d_opcode_i = 3'd1;
      tl_bus.tl_d_source_i = SRC;
      tl_bus.tl_d_error_i  = 1'b1;
      tl_bus.tl_d_data_i   = ~d_data;
    end
    #1;
    chk("gnt", sba_bus.master_gnt_o, 1);
    chk("a_valid", tl_bus.tl_a_valid_o, 1);
    chk("a_opcode", tl_bus.tl_a_opcode_o, e_op);
    chk("a_size", tl_bus.tl_a_size_o, 2);
    chk("a_address", tl_bus.tl_a_address_o, e_addr);
    chk("a_mask", tl_bus.tl_a_mask_o, e_mask);
    chk("a_data", tl_bus.tl_a_data_o, wdata);
    chk("a_source", tl_bus.tl_a_source_o, SRC);
    @(negedge clk);
    tl_bus.tl_d_valid_i = 1'b0;
    for (int k = 1; k < d_dly; k++) begin
      #1;
      chk("wait_gnt", sba_bus.master_gnt_o, 0);
      chk("wait_a_valid", tl_bus.tl_a_valid_o, 0);
      chk("wait_r_valid", sba_bus.master_r_valid_o, 0);
      @(negedge clk);
    end
    tl_bus.tl_d_valid_i  = 1'b1;
    tl_bus.tl_d_opcode_i = d_op;
    tl_bus.tl_d_source_i = d_src;
    tl_bus.tl_d_error_i  = d_err;
    tl_bus.tl_d_data_i   = d_data;
    #1;
    chk("d_ready", tl_bus.tl_d_ready_o, 1);
    chk("d_beat_gnt", sba_bus.master_gnt_o, 0);
    chk("d_beat_r_valid", sba_bus.master_r_valid_o, 0);
    @(negedge clk);
    tl_bus.tl_d_valid_i  = 1'b0;
    sba_bus.master_req_i = 1'b0;
    tl_bus.tl_a_ready_i  = 1'b0;
    #1;
    chk("r_valid", sba_bus.master_r_valid_o, 1);
    chk("err", sba_bus.master_err_o, e_err);
    if (!we) chk("rdata", sba_bus.master_r_rdata_o, d_data);
    @(negedge clk);
    #1;
    chk("r_valid_pulse", sba_bus.master_r_valid_o, 0);
    @(negedge clk);
  endtask

  task automatic stray_beat(input string tag);
    tl_bus.tl_d_valid_i  = 1'b1;
    tl_bus.tl_d_opcode_i = 3'd1;
    tl_bus.tl_d_source_i = SRC;
    tl_bus.tl_d_error_i  = 1'b0;
    tl_bus.tl_d_data_i   = $urandom;
    #1;
    chk({tag, "_d_ready"}, tl_bus.tl_d_ready_o, 1);
    @(negedge clk);
    tl_bus.tl_d_valid_i = 1'b0;
    #1;
    chk({tag, "_r_valid1"}, sba_bus.master_r_valid_o, 0);
    @(negedge clk);
    #1;
    chk({tag, "_r_valid2"}, sba_bus.master_r_valid_o, 0);
    @(negedge clk);
  endtask

  task automatic abort_txn(input bit use_rst);
    sba_bus.master_req_i = 1'b1;
    sba_bus.master_we_i  = 1'b0;
    sba_bus.master_add_i = 32'h4000_0010;
    sba_bus.master_be_i  = 4'h0;
    tl_bus.tl_a_ready_i  = 1'b1;
    #1;
    chk("abort_gnt", sba_bus.master_gnt_o, 1);
    @(negedge clk);
    if (use_rst) begin
      sba_bus.master_req_i = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_r_valid", sba_bus.master_r_valid_o, 0);
      chk("rst_rdata", sba_bus.master_r_rdata_o, 0);
      chk("rst_a_valid", tl_bus.tl_a_valid_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      dmactive = 1'b0;
      #1;
      chk("dmoff_gnt0", sba_bus.master_gnt_o, 0);
      @(negedge clk);
      #1;
      chk("dmoff_a_valid", tl_bus.tl_a_valid_o, 0);
      chk("dmoff_gnt1", sba_bus.master_gnt_o, 0);
      chk("dmoff_r_valid", sba_bus.master_r_valid_o, 0);
      chk("dmoff_rdata", sba_bus.master_r_rdata_o, 0);
      chk("dmoff_err", sba_bus.master_err_o, 0);
      @(negedge clk);
      dmactive = 1'b1;
      sba_bus.master_req_i = 1'b0;
    end
    tl_bus.tl_a_ready_i = 1'b0;
    stray_beat(use_rst ? "rst_late_d" : "dmoff_late_d");
    run_txn(1'b0, 32'h4000_0020, 32'h0, 4'h0, 0, 2,
            3'd1, SRC, 1'b0, 32'hC0FF_EE00 | 32'(use_rst), 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    dmactive = 1'b1;
    sba_bus.master_req_i   = 1'b0;
    sba_bus.master_add_i   = '0;
    sba_bus.master_we_i    = 1'b0;
    sba_bus.master_wdata_i = '0;
    sba_bus.master_be_i    = '0;
    tl_bus.tl_a_ready_i    = 1'b0;
    tl_bus.tl_d_valid_i    = 1'b0;
    tl_bus.tl_d_opcode_i   = '0;
    tl_bus.tl_d_source_i   = '0;
    tl_bus.tl_d_data_i     = '0;
    tl_bus.tl_d_error_i    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_gnt", sba_bus.master_gnt_o, 0);
    chk("reset_r_valid", sba_bus.master_r_valid_o, 0);
    chk("reset_err", sba_bus.master_err_o, 0);
    chk("reset_rdata", sba_bus.master_r_rdata_o, 0);
    chk("reset_a_valid", tl_bus.tl_a_valid_o, 0);
    chk("reset_d_ready", tl_bus.tl_d_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 32'h1000_0004, 32'h0, 4'h0, 0, 3,
            3'd1, SRC, 1'b0, 32'hDEAD_BEEF, 1'b0);
    run_txn(1'b1, 32'h2000_0003, 32'hAA00_0000, 4'h8, 0, 1,
            3'd0, SRC, 1'b0, 32'h0, 1'b0);
    run_txn(1'b1, 32'h3000_0008, 32'h1234_5678, 4'hF, 5, 2,
            3'd0, SRC, 1'b0, 32'h0, 1'b0);
    run_txn(1'b0, 32'h1000_0010, 32'h0, 4'h0, 1, 2,
            3'd1, SRC, 1'b1, 32'h0000_0055, 1'b0);
    run_txn(1'b0, 32'h1000_0014, 32'h0, 4'h0, 0, 1,
            3'd1, 8'd3, 1'b0, 32'h0000_0066, 1'b0);
    run_txn(1'b0, 32'h1000_0018, 32'h0, 4'h0, 0, 2,
            3'd0, SRC, 1'b0, 32'h0000_0077, 1'b0);
    run_txn(1'b1, 32'h1000_001E, 32'h5566_0000, 4'hC, 2, 1,
            3'd1, SRC, 1'b0, 32'h0, 1'b0);
    run_txn(1'b0, 32'h1000_0020, 32'h0, 4'h0, 0, 1,
            3'd1, SRC, 1'b0, 32'h0BAD_F00D, 1'b1);

    stray_beat("idle_stray");
    abort_txn(1'b0);
    abort_txn(1'b1);

    for (int t = 0; t < 24; t++) begin
      bit          r_we;
      logic [3:0]  r_be;
      logic [2:0]  r_op;
      logic [7:0]  r_src;
      bit          r_er;
      int          kind;
      r_we  = 1'($urandom_range(0, 1));
      r_be  = r_we ? 4'($urandom_range(1, 15)) : 4'h0;
      kind  = $urandom_range(0, 7);
      r_op  = r_we ? 3'd0 : 3'd1;
      r_src = SRC;
      r_er  = 1'b0;
      if (kind == 0) r_er = 1'b1;
      else if (kind == 1) r_op = r_op ^ 3'($urandom_range(1, 7));
      else if (kind == 2) r_src = 8'($urandom_range(1, 255));
      run_txn(r_we, $urandom, $urandom, r_be,
              $urandom_range(0, 3), $urandom_range(1, 4),
              r_op, r_src, r_er, $urandom,
              1'($urandom_range(0, 1)));
    end

`ifdef DM_SBA_TLUL_TIMEOUT_EN
    begin : timeout_case
      int n;
      bit seen;
      sba_bus.master_req_i = 1'b1;
      sba_bus.master_we_i  = 1'b0;
      sba_bus.master_add_i = 32'h5000_0000;
      sba_bus.master_be_i  = 4'h0;
      tl_bus.tl_a_ready_i  = 1'b1;
      #1;
      chk("to_gnt", sba_bus.master_gnt_o, 1);
      @(negedge clk);
      sba_bus.master_req_i = 1'b0;
      tl_bus.tl_a_ready_i  = 1'b0;
      n = 1;
      seen = 1'b0;
      while (!seen && n < 64) begin
        #1;
        if (sba_bus.master_r_valid_o) seen = 1'b1;
        else begin
          @(negedge clk);
          n++;
        end
      end
      chk("to_latency", 64'(n), 17);
      chk("to_err", sba_bus.master_err_o, 1);
      chk("to_rdata", sba_bus.master_r_rdata_o, 0);
      @(negedge clk);
      #1;
      chk("to_pulse", sba_bus.master_r_valid_o, 0);
      @(negedge clk);
      stray_beat("to_late_d");
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_sba_tlul_bridge.md
# dm_sba_tlul_bridge

Bridges the debug module's system bus access (SBA) master port onto a TL-UL host port. It sits directly downstream of the SBA engine: it takes its req/gnt/r_valid master interface and issues one outstanding TL-UL transaction at a time. It returns read data, write completion and bus errors on the SBA side as a single-cycle response pulse.

## Interface
- Parameters:
- `BusWidth`, 32: data/address width; 32 or 64.
- `SourceId`, 0: value driven on `tl_a_source_o`; also the expected `tl_d_source_i`.
- `TimeoutCycles`, 1024: D-channel wait limit. Used only when the timeout feature is compiled in.
- Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `dmactive_i` in 1: synchronous clear when low.
- `master_req_i` in 1: SBA request.
- `master_add_i` in BusWidth: byte address.
- `master_we_i` in 1: write.
- `master_wdata_i` in BusWidth: write data.
- `master_be_i` in BusWidth/8: byte enables; all-zero on reads.
- `master_gnt_o` out 1: request accepted.
- `master_r_valid_o` out 1: response pulse, for reads and writes.
- `master_r_rdata_o` out BusWidth: read data.
- `master_err_o` out 1: error flag, qualified by `master_r_valid_o`.
- `tl_a_valid_o` out 1, `tl_a_ready_i` in 1: A-channel handshake.
- `tl_a_opcode_o` out 3, `tl_a_size_o` out 2, `tl_a_address_o` out BusWidth, `tl_a_mask_o` out BusWidth/8, `tl_a_data_o` out BusWidth, `tl_a_source_o` out 8: A-channel payload.
- `tl_d_valid_i` in 1, `tl_d_ready_o` out 1: D-channel handshake.
- `tl_d_opcode_i` in 3, `tl_d_source_i` in 8, `tl_d_data_i` in BusWidth, `tl_d_error_i` in 1: D-channel payload.

## Operation
- FSM states: Idle, WaitD, Resp.
- Idle:
- `tl_a_valid_o` = `master_req_i`. A-payload is combinational from the master inputs.
- `master_gnt_o` = `master_req_i & tl_a_ready_i`.
- On grant, go to WaitD and latch `we` into an expected-opcode register.
- Opcode mapping:
- Read: Get (4), mask all-ones.
- Write with `be` all-ones: PutFullData (0).
- Otherwise: PutPartialData (1), mask = `be`.
- Every access uses a full-word size, `$clog2(BusWidth/8)`. The address has its low `$clog2(BusWidth/8)` bits cleared. Sub-word selection is carried only by the mask.
- WaitD: `tl_d_ready_o`=1. On `tl_d_valid_i`, register the response and go to Resp:
- read data <- `tl_d_data_i`;
- err <- `tl_d_error_i`, OR wrong opcode (AccessAckData=1 expected for Get, AccessAck=0 for Put), OR `tl_d_source_i != SourceId`.
- Resp: `master_r_valid_o`=1 for exactly one cycle, with `master_r_rdata_o` and `master_err_o` from the registers. Then go to Idle.
- `tl_d_ready_o`=1 in Idle as well. Stray D beats in Idle are accepted and discarded, with no SBA response.
- No new request is granted in WaitD or Resp: `tl_a_valid_o`=0 and `master_gnt_o`=0.
- `dmactive_i`=0: FSM returns to Idle next cycle, response registers clear, and `tl_a_valid_o` is forced 0. An in-flight D response arriving later is drained as stray.

## Timing
- Reset values:
- FSM = Idle.
- `master_r_valid_o`, `master_err_o`, `master_gnt_o`, `tl_a_valid_o` = 0.
- `master_r_rdata_o` = 0.
- `tl_d_ready_o` = 1.
- Grant is combinational in the same cycle as the A handshake. The A payload must stay stable while `tl_a_valid_o` is high and `tl_a_ready_i` is low; the SBA engine guarantees this.
- Minimum latency, grant to `master_r_valid_o`:
- D handshake no earlier than the cycle after the grant;
- then `master_r_valid_o` one cycle after the D handshake;
- so the minimum is 2 cycles.
- `tl_d_valid_i` in the grant cycle is treated as stray. Zero-latency responders are not supported.
- Reset asserted mid-transaction: asynchronous return to Idle; no response is delivered to SBA.
- If `master_req_i` drops before `tl_a_ready_i`, `tl_a_valid_o` drops with it. TL-UL protocol is still met because the SBA engine only drops req on an error abort.

## Configuration
- `DM_SBA_TLUL_TIMEOUT_EN` defined:
- In WaitD a counter increments every cycle.
- On reaching `TimeoutCycles-1` with no D beat, go to Resp with err=1 and rdata=0.
- A later stray D beat is discarded.
- The counter clears on entering WaitD.
- Not defined: no counter; WaitD waits indefinitely.

## Structure
- TL-UL opcode enum (Get, PutFullData, PutPartialData, AccessAck, AccessAckData) and size type belong in the shared `tlul_pkg`.
- FSM state enum is local.
- One natural sub-module, `dm_sba_timeout`: a counter with start/clear/expire. It is instantiated only under `DM_SBA_TLUL_TIMEOUT_EN`.

## Test plan
- Read 0x1000_0004, responder returns AccessAckData data 0xDEADBEEF after 3 cycles -> A: Get, address 0x1000_0004, mask 0xF; one `master_r_valid_o` pulse with rdata 0xDEADBEEF, err 0.
- Byte write, address 0x2000_0003, be 0x8, data 0xAA000000 -> A: PutPartialData, mask 0x8, address 0x2000_0000; AccessAck -> r_valid, err 0.
- Word write, be 0xF -> PutFullData; `tl_a_ready_i` held low 5 cycles -> `master_gnt_o` only in the ready cycle; exactly one A handshake.
- `tl_d_error_i`=1, then separately a source mismatch (source 3, SourceId 0) -> r_valid with err 1 in both cases.
- Reset pulsed and `dmactive_i` low while in WaitD -> Idle, no r_valid; the late D beat is consumed silently and the next request is served normally.
- With `DM_SBA_TLUL_TIMEOUT_EN` and `TimeoutCycles`=16, no D response -> r_valid with err 1 and rdata 0, 17 cycles after the grant.
